tri_attr_interp: RTL
====================

TRI_ATTR_INTERP -- requirements
Module: tri_attr_interp

Interface
REQ-001 SHALL have parameter NCH, default 5: number of interpolated attribute channels (>=1).
REQ-002 SHALL have parameter AW, default 8: attribute width in bits, unsigned.
REQ-003 SHALL have parameter FW, default 20: fraction bits of u/v; u and v are FW+1 bits, unsigned 1.FW.
REQ-004 SHALL have parameter XW, default 9 and YW, default 8: pixel coordinate widths.
REQ-005 SHALL have parameter DEPTH, default 16: input FIFO depth (power of 2, >=4).
REQ-006 SHALL have parameter CLAMP, default 1: 1 = saturate results, 0 = wrap.
REQ-007 SHALL have port clk_i, input, 1: the only clock; all logic on its rising edge.
REQ-008 SHALL have port reset_n_i, input, 1: reset is synchronous and active-low.
REQ-009 SHALL have port in_valid_i, input, 1: input word valid.
REQ-010 SHALL have port in_ready_o, output, 1: FIFO can accept a word.
REQ-011 SHALL have port in_data_i, input, XW+YW+3*NCH*AW+2*(FW+1), packed MSB->LSB {x, y, A2, A1, A0, u, v}; each Ak = channels NCH-1..0, AW bits each.
REQ-012 SHALL have port out_valid_o, output, 1: output word valid.
REQ-013 SHALL have port out_ready_i, input, 1: downstream accepts.
REQ-014 SHALL have port out_data_o, output, XW+YW+NCH*AW: {x, y, R[NCH-1..0]}.
REQ-015 SHALL have port out_uverr_o, output, 1: qualified by out_valid_o; u+v exceeded 1.0 for this word.
REQ-016 SHALL have port fifo_level_o, output, log2(DEPTH)+1: current FIFO occupancy.

Function
REQ-017 SHALL accept a word only on in_valid_i && in_ready_o; in_ready_o = (level < DEPTH), registered-level based, no combinational path from out_ready_i.
REQ-018 SHALL maintain FIFO order; simultaneous push and pop at level DEPTH or 0 SHALL be handled (pop-while-full frees a slot next cycle; push-while-empty is not bypassed).
REQ-019 SHALL process words through pipeline F (FIFO read reg) -> S1 (differences d1=A1-A0, d2=A2-A0, AW+1 signed) -> S2 (products u*d1, v*d2, FW+AW+2 signed) -> S3 (sum, round, clamp, into output register).
REQ-020 SHALL compute per channel S = (A0<<FW) + u*d1 + v*d2 + 2^(FW-1) in FW+AW+3 bits signed; R = S>>FW (round half up).
REQ-021 With CLAMP=1, R<0 SHALL output 0 and R>2^AW-1 SHALL output 2^AW-1; with CLAMP=0, output R[AW-1:0].
REQ-022 SHALL set out_uverr_o when u+v > 2^FW (compared in FW+2 bits); data still computed per REQ-020/021.
REQ-023 SHALL pass x, y through unchanged, aligned with their channels.
REQ-024 Latency: word accepted in cycle t into an empty block with out_ready_i high SHALL appear with out_valid_o in cycle t+4.
REQ-025 Throughput: one word per cycle sustained while out_ready_i high.
REQ-026 Stall: when out_valid_o && !out_ready_i, out_data_o/out_uverr_o SHALL hold stable and the pipeline SHALL advance only into empty stages (bubble collapse); no word lost or duplicated.
REQ-027 out_valid_o SHALL not deassert until the word is accepted.
REQ-028 fifo_level_o SHALL reflect push/pop of the previous edge, saturating at DEPTH and never below 0.

Reset
REQ-029 On a clk_i edge with reset_n_i low: FIFO level 0, all stage valids 0, out_valid_o 0, in_ready_o 1 from the next cycle, out_data_o 0, out_uverr_o 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight and buffered words; no output valid after release until a new word is accepted.
REQ-031 in_valid_i during reset SHALL be ignored.

Verification
REQ-032 Default params, A0=10,A1=110,A2=210 all channels, u=v=0.25 (2^18), x=5,y=7 -> after 4 cycles out_valid_o, each R=85, x=5,y=7, uverr 0.
REQ-033 A0=250,A1=255,A2=255, u=v=0.5, CLAMP=1 -> R=255; A0=0,A1=0,A2=0 w/ u=1.0 -> R=0; CLAMP=0, A0=200,A1=255,A2=0, u=1.0,v=0.5 -> R=155, uverr=1.
REQ-034 Hold out_ready_i low, push 20 words -> in_ready_o low once level=16, fifo_level_o=16, no overflow; release -> all 20 out in order, stable data during stall.
REQ-035 Back-to-back 100 random words, random out_ready_i -> output sequence matches scoreboard model (REQ-020/021) exactly.
REQ-036 Pulse reset_n_i low 1 cycle with 3 words buffered and 2 in pipeline -> out_valid_o 0, fifo_level_o 0, next accepted word emerges after 4 cycles.

Source files
------------

// File: rtl/tri_attr_interp.sv
// Barycentric attribute interpolator: FIFO-buffered, elastic pipeline computing
// R = A0 + u*(A1-A0) + v*(A2-A0) per channel with round-half-up and optional saturation.
module tri_attr_interp #(
    parameter int NCH   = 5,
    parameter int AW    = 8,
    parameter int FW    = 20,
    parameter int XW    = 9,
    parameter int YW    = 8,
    parameter int DEPTH = 16,
    parameter int CLAMP = 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [XW+YW+3*NCH*AW+2*(FW+1)-1:0]   in_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [XW+YW+NCH*AW-1:0]              out_data_o,
    output logic                                 out_uverr_o,
    output logic [$clog2(DEPTH):0]               fifo_level_o
);
    localparam int IW     = XW + YW + 3*NCH*AW + 2*(FW+1);
    localparam int PW     = $clog2(DEPTH);
    localparam int DW     = AW + 1;
    localparam int MW     = FW + AW + 2;
    localparam int SW     = FW + AW + 3;
    localparam int A0_LSB = 2*(FW+1);
    localparam int A1_LSB = A0_LSB + NCH*AW;
    localparam int A2_LSB = A1_LSB + NCH*AW;
    localparam int Y_LSB  = A2_LSB + NCH*AW;
    localparam int X_LSB  = Y_LSB + YW;

    localparam logic [PW:0]          FULL_LEVEL = (PW+1)'(DEPTH);
    localparam logic [FW+1:0]        UV_ONE     = {2'b01, {FW{1'b0}}};
    localparam logic signed [SW-1:0] ROUND      = {{(SW-FW){1'b0}}, 1'b1, {(FW-1){1'b0}}};

    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   level;
    logic          push, pop;

    logic s1_valid, s2_valid, out_valid;
    logic rdy_out, rdy_s2, rdy_s1;

    logic [AW-1:0]        s1_a0 [NCH];
    logic signed [DW-1:0] s1_d1 [NCH];
    logic signed [DW-1:0] s1_d2 [NCH];
    logic [FW:0]          s1_u, s1_v;
    logic [XW-1:0]        s1_x;
    logic [YW-1:0]        s1_y;

    logic [AW-1:0]        s2_a0 [NCH];
    logic signed [MW-1:0] s2_p1 [NCH];
    logic signed [MW-1:0] s2_p2 [NCH];
    logic                 s2_uverr;
    logic [XW-1:0]        s2_x;
    logic [YW-1:0]        s2_y;

    logic signed [SW-1:0] sum_c [NCH];
    logic [AW+2:0]        r_c   [NCH];
    logic [NCH*AW-1:0]    res_vec;

    // A stage may load whenever it is empty or its occupant leaves this cycle.
    assign rdy_out = !out_valid || out_ready_i;
    assign rdy_s2  = !s2_valid  || rdy_out;
    assign rdy_s1  = !s1_valid  || rdy_s2;

    assign in_ready_o   = level < FULL_LEVEL;
    assign push         = in_valid_i && in_ready_o;
    assign pop          = (level != '0) && rdy_s1;
    assign head         = mem[rd_ptr];
    assign fifo_level_o = level;
    assign out_valid_o  = out_valid;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + (PW+1)'(1);
                2'b01:   level <= level - (PW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && reset_n_i) mem[wr_ptr] <= in_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (rdy_s1)  s1_valid  <= pop;
            if (rdy_s2)  s2_valid  <= s1_valid;
            if (rdy_out) out_valid <= s2_valid;
        end
    end

    // The FIFO read register also captures the vertex differences, keeping latency at four.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            for (int k = 0; k < NCH; k++) begin
                s1_a0[k] <= head[A0_LSB + k*AW +: AW];
                s1_d1[k] <= $signed({1'b0, head[A1_LSB + k*AW +: AW]}) - $signed({1'b0, head[A0_LSB + k*AW +: AW]});
                s1_d2[k] <= $signed({1'b0, head[A2_LSB + k*AW +: AW]}) - $signed({1'b0, head[A0_LSB + k*AW +: AW]});
            end
            s1_u <= head[FW+1 +: FW+1];
            s1_v <= head[FW:0];
            s1_x <= head[X_LSB +: XW];
            s1_y <= head[Y_LSB +: YW];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rdy_s2 && s1_valid) begin
            for (int k = 0; k < NCH; k++) begin
                s2_a0[k] <= s1_a0[k];
                s2_p1[k] <= MW'($signed({1'b0, s1_u})) * MW'(s1_d1[k]);
                s2_p2[k] <= MW'($signed({1'b0, s1_v})) * MW'(s1_d2[k]);
            end
            s2_uverr <= ({1'b0, s1_u} + {1'b0, s1_v}) > UV_ONE;
            s2_x     <= s1_x;
            s2_y     <= s1_y;
        end
    end

    always_comb begin
        res_vec = '0;
        for (int k = 0; k < NCH; k++) begin
            sum_c[k] = (SW'($signed({1'b0, s2_a0[k]})) <<< FW) + SW'(s2_p1[k]) + SW'(s2_p2[k]) + ROUND;
            r_c[k]   = (AW+3)'(sum_c[k] >>> FW);
            if (CLAMP != 0 && r_c[k][AW+2])
                res_vec[k*AW +: AW] = '0;
            else if (CLAMP != 0 && (|r_c[k][AW+1:AW]))
                res_vec[k*AW +: AW] = '1;
            else
                res_vec[k*AW +: AW] = r_c[k][AW-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            out_data_o  <= '0;
            out_uverr_o <= 1'b0;
        end else if (rdy_out && s2_valid) begin
            out_data_o  <= {s2_x, s2_y, res_vec};
            out_uverr_o <= s2_uverr;
        end
    end

endmodule
